ripple_count_ctrl: RTL and testbench

Sequencer and checker for the team's WIDTH-bit ripple counter datapath.
- Accepts a start command with a target count.
- Holds the counter in reset, then enables it for exactly `target` clock cycles.
- Waits a settle window so ripple outputs become stable, then samples the counter output and compares it with the target.
- Reports done, the final count and a mismatch error.
- Sits between the control/test logic and the counter; it is the only driver of the counter's reset and enable.

---
 rtl/ripple_count_ctrl.sv | 142 ++++++++++++++
 tb/tb_ripple_count_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ripple_count_ctrl.sv
// Sequencer/checker for a WIDTH-bit ripple counter: clear, enable for exactly
// `target` cycles, wait for ripple settling, then sample and compare.
module ripple_count_ctrl #(
  parameter int WIDTH      = 4,
  parameter int CLR_CYCLES = 2,
  parameter int SETTLE     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_rst,
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] count_out,
  output logic [2:0]       dbg_state
);

  localparam int MAX_PH = (CLR_CYCLES > SETTLE) ? CLR_CYCLES : SETTLE;
  localparam int CW_PH  = $clog2(MAX_PH) + 1;
  localparam int CW     = (WIDTH > CW_PH) ? WIDTH : CW_PH;

  localparam logic [CW-1:0] CLR_M1    = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_SETTLE = 3'd3,
    S_CHECK  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             cnt_rst_q, cnt_rst_d;
  logic             cnt_en_q, cnt_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // cyc_q counts down the remaining cycles of the current timed phase.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    target_d = target_q;
    err_d    = err_q;
    count_d  = count_q;
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d  = S_CLEAR;
            target_d = target;
            err_d    = 1'b0;
            cyc_d    = CLR_M1;
          end
        end
        S_CLEAR: begin
          if (cyc_q == '0) begin
            if (target_q == '0) begin
              state_d = S_SETTLE;
              cyc_d   = SETTLE_M1;
            end else begin
              state_d = S_RUN;
              cyc_d   = CW'(target_q) - CW'(1);
            end
          end else begin
            cyc_d = cyc_q - CW'(1);
          end
        end
        S_RUN: begin
          if (cyc_q == '0) begin
            state_d = S_SETTLE;
            cyc_d   = SETTLE_M1;
          end else begin
            cyc_d = cyc_q - CW'(1);
          end
        end
        S_SETTLE: begin
          if (cyc_q == '0) state_d = S_CHECK;
          else             cyc_d   = cyc_q - CW'(1);
        end
        S_CHECK: begin
          count_d = cnt_q;
          err_d   = (cnt_q != target_q);
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they move with the state edge.
  always_comb begin
    cnt_rst_d = (state_d == S_IDLE) || (state_d == S_CLEAR);
    cnt_en_d  = (state_d == S_RUN);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_q == S_CHECK) && !abort;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      target_q  <= '0;
      err_q     <= 1'b0;
      count_q   <= '0;
      cnt_rst_q <= 1'b1;
      cnt_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      target_q  <= target_d;
      err_q     <= err_d;
      count_q   <= count_d;
      cnt_rst_q <= cnt_rst_d;
      cnt_en_q  <= cnt_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign cnt_rst   = cnt_rst_q;
  assign cnt_en    = cnt_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign count_out = count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ripple_count_ctrl.sv
// Randomized bench for ripple_count_ctrl with a behavioural ripple counter and
// a run-level timing model (phase lengths computed from the run parameters).
module tb_ripple_count_ctrl;

  localparam int W   = 4;
  localparam int CLR = 2;
  localparam int SET = 3;

  logic         clk, rst, start, abort;
  logic [W-1:0] target, cnt_q, count_out;
  logic         cnt_rst, cnt_en, busy, done, err;
  logic [2:0]   dbg_state;
  logic [3:0]   ctl;

  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;
  int exp_err = 0;

  // Ripple counter model: counts enabled edges, can drop one increment.
  logic [W-1:0] edges;
  logic         drop_arm;

  ripple_count_ctrl #(.WIDTH(W), .CLR_CYCLES(CLR), .SETTLE(SET)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .target(target),
    .cnt_q(cnt_q), .cnt_rst(cnt_rst), .cnt_en(cnt_en), .busy(busy),
    .done(done), .err(err), .count_out(count_out), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_rst)     edges <= '0;
    else if (cnt_en) edges <= edges + 4'd1;
  end
  assign #2 cnt_q = (drop_arm && edges != '0) ? edges - 4'd1 : edges;

  assign ctl = {busy, cnt_rst, cnt_en, done};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One run: start at the current negedge; c indexes observations after edge E0+c.
  task automatic run(input int tgt, input bit drop, input int abort_c,
                     input bit poke, input bit chain);
    int  len = CLR + tgt + SET + 1;
    bit  d = drop && (tgt != 0);
    bit  aborted = 0;
    logic [3:0] exp_v;
    drop_arm = d;
    start  = 1'b1;
    target = W'(tgt);
    @(posedge clk);
    for (int c = 0; c <= len; c++) begin
      @(negedge clk);
      start  = 1'b0;
      target = W'($urandom_range(0, 15));
      if (aborted) begin
        abort = 1'b0;
        check_eq("abort_ctl", 32'(ctl), 32'b0100);
        check_eq("abort_cnt", 32'(count_out), 32'(exp_cnt));
        check_eq("abort_err", 32'(err), 32'(exp_err));
        @(negedge clk);
        check_eq("abort_nodone", 32'(ctl), 32'b0100);
        return;
      end
      exp_v = {c < len, (c < CLR) || (c >= len),
               (c >= CLR) && (c < CLR + tgt), c == len};
      check_eq("ctl", 32'(ctl), 32'(exp_v));
      if (c == 0) begin
        check_eq("err_clr", 32'(err), 32'd0);
        check_eq("cnt_hold", 32'(count_out), 32'(exp_cnt));
      end
      if (poke && c == CLR + tgt) begin
        start  = 1'b1;
        target = W'($urandom_range(0, 15));
      end
      if (c == len) begin
        exp_cnt = d ? tgt - 1 : tgt;
        exp_err = d ? 1 : 0;
        check_eq("count_out", 32'(count_out), 32'(exp_cnt));
        check_eq("err", 32'(err), 32'(exp_err));
        if (!chain) begin
          @(negedge clk);
          check_eq("post_done", 32'(ctl), 32'b0100);
        end
        return;
      end
      if (c == abort_c) begin
        abort   = 1'b1;
        aborted = 1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; target = '0; drop_arm = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ctl", 32'(ctl), 32'b0100);
    check_eq("rst_cnt", 32'(count_out), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // start with abort in IDLE: stay idle
    start = 1'b1; abort = 1'b1; target = 4'd7;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq("abort_start_idle", 32'(ctl), 32'b0100);
    @(negedge clk);

    run(5, 0, -1, 0, 0);
    run(0, 0, -1, 0, 0);
    run(15, 0, -1, 0, 0);
    run(6, 1, -1, 0, 0);
    run(3, 0, -1, 0, 0);
    run(9, 0, CLR + 3, 0, 0);
    run(4, 0, -1, 1, 0);
    @(negedge clk);
    check_eq("poke_ignored", 32'(ctl), 32'b0100);
    run(7, 0, -1, 0, 1);
    run(2, 0, -1, 0, 0);

    // async reset in the middle of RUN
    start = 1'b1; target = 4'd9; drop_arm = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (CLR + 2) @(negedge clk);
    check_eq("pre_rst_run", 32'(ctl), 32'b1010);
    #2 rst = 1'b1;
    #1;
    check_eq("midrun_rst_ctl", 32'(ctl), 32'b0100);
    check_eq("midrun_rst_cnt", 32'(count_out), 32'd0);
    check_eq("midrun_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0; exp_err = 0;
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      int t  = $urandom_range(0, 15);
      int ln = CLR + t + SET + 1;
      bit dr = ($urandom_range(0, 3) == 0);
      int ac = ($urandom_range(0, 4) == 0) ? $urandom_range(0, ln - 1) : -1;
      bit pk = ($urandom_range(0, 3) == 0);
      bit ch = (ac < 0) && !pk && ($urandom_range(0, 2) == 0);
      run(t, dr, ac, pk, ch);
      if (pk && ac < 0) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
